// File: rtl/athena_hiscore_dma_if.sv
// Signal bundle between athena_hiscore_dma and its surroundings: bridge port,
// DMA requests/status and the CPU RAM arbiter port.
interface athena_hiscore_dma_if;
   logic [31:0] bridge_addr;
   logic        bridge_wr;
   logic [31:0] bridge_wr_data;
   logic        bridge_rd;
   logic [31:0] bridge_rd_data;
   logic        restore_req;
   logic        save_req;
   logic        ram_req;
   logic        ram_gnt;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        busy;
   logic        done;

   modport slave (
      input  bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
      input  restore_req, save_req, ram_gnt, ram_rdata,
      output bridge_rd_data, ram_req, ram_addr, ram_we, ram_wdata, busy, done
   );

   modport master (
      output bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
      output restore_req, save_req, ram_gnt, ram_rdata,
      input  bridge_rd_data, ram_req, ram_addr, ram_we, ram_wdata, busy, done
   );
endinterface

// File: rtl/athena_hiscore_dma.sv
// Hiscore buffer (bridge dataslot window) with a DMA engine that restores it to,
// or saves it from, CPU work RAM. Optional macro ATHENA_HISCORE_VALID_EN gates restore.
module athena_hiscore_dma #(
   parameter logic [31:0] BRIDGE_START = 32'h1000_0000,
   parameter logic [31:0] BRIDGE_END   = 32'h1000_00FF,
   parameter logic [15:0] CPU_BASE     = 16'hFE50,
   parameter int          NUM_WORDS    = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   athena_hiscore_dma_if.slave  bus
);
   localparam int AW = $clog2(NUM_WORDS);
   localparam int NW = AW + 2;
   localparam logic [NW-1:0] LAST_BYTE = NW'(4 * NUM_WORDS - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_RST_FETCH = 3'd1;
   localparam logic [2:0] S_RST_WRITE = 3'd2;
   localparam logic [2:0] S_SAV_READ  = 3'd3;
   localparam logic [2:0] S_DONE      = 3'd4;

   logic [31:0]   r_mem [NUM_WORDS];
   logic [2:0]    r_state;
   logic [NW-1:0] r_n;
   logic [NW-1:0] r_cap_n;
   logic [31:0]   r_word;
   logic          r_rd_pend;
   logic          r_ram_req;
   logic          r_ram_we;
   logic [15:0]   r_ram_addr;
   logic [7:0]    r_ram_wdata;
   logic          r_busy;
   logic          r_done;
   logic [31:0]   r_rd_data;

   logic          w_in_win;
   logic [AW-1:0] w_br_idx;
   logic          w_br_we;
   logic          w_br_re;
   logic          w_gnt;
   logic [31:0]   w_cap_word;
   logic          w_dma_we;
   logic [AW-1:0] w_dma_idx;
   logic [AW-1:0] w_next_idx;
   logic [31:0]   w_next_word;
   logic          w_restore_go;
   logic          w_save_go;

   assign w_in_win    = (bus.bridge_addr >= BRIDGE_START) && (bus.bridge_addr <= BRIDGE_END);
   assign w_br_idx    = bus.bridge_addr[AW+1:2];
   assign w_br_we     = bus.bridge_wr & w_in_win;
   assign w_br_re     = bus.bridge_rd & w_in_win;
   assign w_gnt       = r_ram_req & bus.ram_gnt;
   assign w_cap_word  = {r_word[23:0], bus.ram_rdata};
   assign w_dma_idx   = r_cap_n[NW-1:2];
   assign w_dma_we    = reset_n && (r_state == S_SAV_READ) && r_rd_pend && (r_cap_n[1:0] == 2'd3);
   assign w_next_idx  = r_n[NW-1:2] + AW'(1);
   assign w_next_word = r_mem[w_next_idx];
   assign w_save_go   = bus.save_req;

`ifdef ATHENA_HISCORE_VALID_EN
   logic r_valid;

   // Buffer holds real data only once the bridge has written into it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
      end else if (w_br_we) begin
         r_valid <= 1'b1;
      end
   end

   assign w_restore_go = bus.restore_req & r_valid;
`else
   assign w_restore_go = bus.restore_req;
`endif

   // Buffer storage survives reset; the DMA write wins a same-word collision.
   always_ff @(posedge clk) begin
      if (w_dma_we) begin
         r_mem[w_dma_idx] <= w_cap_word;
      end
      if (w_br_we && !(w_dma_we && (w_dma_idx == w_br_idx))) begin
         r_mem[w_br_idx] <= bus.bridge_wr_data;
      end
   end

   // Registered bridge read port; out-of-window reads leave the data alone.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rd_data <= 32'h0000_0000;
      end else if (w_br_re) begin
         r_rd_data <= r_mem[w_br_idx];
      end
   end

   // DMA sequencer: r_word doubles as the restore byte shifter and save assembler.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_n         <= '0;
         r_cap_n     <= '0;
         r_word      <= 32'h0000_0000;
         r_rd_pend   <= 1'b0;
         r_ram_req   <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= CPU_BASE;
         r_ram_wdata <= 8'h00;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_rd_pend <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_restore_go) begin
                  r_state <= S_RST_FETCH;
                  r_busy  <= 1'b1;
               end else if (w_save_go) begin
                  r_state    <= S_SAV_READ;
                  r_busy     <= 1'b1;
                  r_ram_req  <= 1'b1;
                  r_ram_we   <= 1'b0;
                  r_ram_addr <= CPU_BASE;
                  r_n        <= '0;
                  r_cap_n    <= '0;
               end
            end
            S_RST_FETCH: begin
               r_word      <= r_mem[0];
               r_ram_wdata <= r_mem[0][31:24];
               r_ram_req   <= 1'b1;
               r_ram_we    <= 1'b1;
               r_ram_addr  <= CPU_BASE;
               r_n         <= '0;
               r_state     <= S_RST_WRITE;
            end
            S_RST_WRITE: begin
               if (w_gnt) begin
                  if (r_n == LAST_BYTE) begin
                     r_ram_req <= 1'b0;
                     r_ram_we  <= 1'b0;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     r_n        <= r_n + NW'(1);
                     r_ram_addr <= r_ram_addr + 16'd1;
                     if (r_n[1:0] == 2'd3) begin
                        r_word      <= w_next_word;
                        r_ram_wdata <= w_next_word[31:24];
                     end else begin
                        r_word      <= {r_word[23:0], 8'h00};
                        r_ram_wdata <= r_word[23:16];
                     end
                  end
               end
            end
            S_SAV_READ: begin
               r_rd_pend <= w_gnt;
               if (w_gnt) begin
                  if (r_n == LAST_BYTE) begin
                     r_ram_req <= 1'b0;
                  end else begin
                     r_n        <= r_n + NW'(1);
                     r_ram_addr <= r_ram_addr + 16'd1;
                  end
               end
               // Read data arrives one cycle after its grant.
               if (r_rd_pend) begin
                  r_word  <= w_cap_word;
                  r_cap_n <= r_cap_n + NW'(1);
                  if (r_cap_n == LAST_BYTE) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state   <= S_IDLE;
               r_ram_req <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.bridge_rd_data = r_rd_data;
   assign bus.ram_req        = r_ram_req;
   assign bus.ram_addr       = r_ram_addr;
   assign bus.ram_we         = r_ram_we;
   assign bus.ram_wdata      = r_ram_wdata;
   assign bus.busy           = r_busy;
   assign bus.done           = r_done;
endmodule

// File: tb/tb_athena_hiscore_dma.sv
// Directed bench for athena_hiscore_dma: scoreboarded restore writes, RAM model
// returning low address byte for saves, stall, collision-of-requests and reset cases.
module tb_athena_hiscore_dma;
   logic clk;
   logic reset_n;
   athena_hiscore_dma_if bus();

   athena_hiscore_dma dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          wr_cnt   = 0;
   int          rd_cnt   = 0;
   int          done_cnt = 0;
   logic [23:0] exp_q[$];
   logic [31:0] tb_buf [64];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // CPU RAM model: writes are scoreboarded, reads return the low address byte.
   always @(posedge clk) begin
      logic [23:0] e;
      if (bus.ram_req && bus.ram_gnt && bus.ram_we) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            check("ram_wr_extra", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("ram_wr", {8'h00, bus.ram_addr, bus.ram_wdata}, {8'h00, e});
         end
      end
      if (bus.ram_req && bus.ram_gnt && !bus.ram_we) rd_cnt++;
      if (bus.done) done_cnt++;
      bus.ram_rdata <= (bus.ram_req && bus.ram_gnt && !bus.ram_we) ? bus.ram_addr[7:0] : 8'hEE;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bwrite(input logic [31:0] addr, input logic [31:0] data);
      bus.bridge_addr    = addr;
      bus.bridge_wr_data = data;
      bus.bridge_wr      = 1'b1;
      tick();
      bus.bridge_wr      = 1'b0;
   endtask

   task automatic bread(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      bus.bridge_addr = addr;
      bus.bridge_rd   = 1'b1;
      tick();
      bus.bridge_rd   = 1'b0;
      check(tag, bus.bridge_rd_data, exp);
   endtask

   task automatic push_restore();
      logic [31:0] wv;
      logic [15:0] a;
      logic [7:0]  b;
      for (int n = 0; n < 256; n++) begin
         wv = tb_buf[n >> 2];
         b  = 8'(wv >> (8 * (3 - (n & 3))));
         a  = 16'hFE50 + 16'(n);
         exp_q.push_back({a, b});
      end
   endtask

   task automatic save_expect();
      logic [15:0] a;
      for (int w = 0; w < 64; w++) begin
         for (int k = 0; k < 4; k++) begin
            a = 16'hFE50 + 16'(4 * w + k);
            tb_buf[w][31 - 8 * k -: 8] = a[7:0];
         end
      end
   endtask

   task automatic run_dma(input bit restore, input bit stall, input string tag);
      int c;
      int stalls;
      if (restore) bus.restore_req = 1'b1;
      else         bus.save_req    = 1'b1;
      tick();
      bus.restore_req = 1'b0;
      bus.save_req    = 1'b0;
      c = 1;
      stalls = 0;
      check({tag, "_busy_c1"}, 32'(bus.busy), 32'd1);
      check({tag, "_req_c1"}, 32'(bus.ram_req), restore ? 32'd0 : 32'd1);
      while (bus.done !== 1'b1 && c < 2000) begin
         if (c == 2) check({tag, "_req_c2"}, 32'(bus.ram_req), 32'd1);
         bus.ram_gnt = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.ram_req && !bus.ram_gnt) stalls++;
         tick();
         c++;
      end
      bus.ram_gnt = 1'b1;
      check({tag, "_done_cycle"}, 32'(c), 32'(258 + stalls));
      check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      tick();
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int c;
      int d0;
      reset_n            = 1'b0;
      bus.bridge_addr    = 32'h0;
      bus.bridge_wr      = 1'b0;
      bus.bridge_wr_data = 32'h0;
      bus.bridge_rd      = 1'b0;
      bus.restore_req    = 1'b0;
      bus.save_req       = 1'b0;
      bus.ram_gnt        = 1'b1;
      tick();
      tick();
      check("rst_rd_data", bus.bridge_rd_data, 32'h0);
      check("rst_ram_req", 32'(bus.ram_req), 32'd0);
      check("rst_ram_we", 32'(bus.ram_we), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_ram_addr", 32'(bus.ram_addr), 32'h0000_FE50);
      check("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
      reset_n = 1'b1;
      tick();

`ifdef ATHENA_HISCORE_VALID_EN
      bus.restore_req = 1'b1;
      tick();
      bus.restore_req = 1'b0;
      c = 0;
      for (int i = 0; i < 300; i++) begin
         if (bus.ram_req) c++;
         tick();
      end
      check("valid_no_req", 32'(c), 32'd0);
      check("valid_no_done", 32'(done_cnt), 32'd0);
`endif

      // Fill buffer, probe window edges.
      for (int w = 0; w < 64; w++) begin
         tb_buf[w] = (w == 0) ? 32'h1122_3344 : $urandom;
         bwrite(32'h1000_0000 + 32'(4 * w), tb_buf[w]);
      end
      bwrite(32'h1000_0100, 32'hBAD0_BAD0);
      bwrite(32'h0FFF_FFFC, 32'hBAD1_BAD1);
      bread("rd_word0", 32'h1000_0000, 32'h1122_3344);
      bread("rd_word63", 32'h1000_00FC, tb_buf[63]);
      bread("rd_out_of_win", 32'h1000_0104, tb_buf[63]);

      // Restore, grant always high.
      wr_cnt = 0;
      push_restore();
      run_dma(1'b1, 1'b0, "restore");
      check("restore_wr_cnt", 32'(wr_cnt), 32'd256);
      check("restore_q_empty", 32'(exp_q.size()), 32'd0);

      // Save, grant always high.
      rd_cnt = 0;
      run_dma(1'b0, 1'b0, "save");
      check("save_rd_cnt", 32'(rd_cnt), 32'd256);
      save_expect();
      bread("save_word0", 32'h1000_0000, 32'h5051_5253);
      bread("save_word63", 32'h1000_00FC, 32'h4C4D_4E4F);
      for (int w = 1; w < 63; w++) bread("save_word", 32'h1000_0000 + 32'(4 * w), tb_buf[w]);

      // Save with random stalls after scribbling over the buffer.
      bwrite(32'h1000_0000, 32'hDEAD_BEEF);
      bwrite(32'h1000_007C, 32'hDEAD_BEEF);
      bwrite(32'h1000_00FC, 32'hDEAD_BEEF);
      run_dma(1'b0, 1'b1, "save_stall");
      for (int w = 0; w < 64; w++) bread("stall_word", 32'h1000_0000 + 32'(4 * w), tb_buf[w]);

      // Both requests together, then a save and bridge write mid-restore.
      tb_buf[60] = 32'hA1B2_C3D4;
      wr_cnt = 0;
      rd_cnt = 0;
      d0 = done_cnt;
      push_restore();
      bus.restore_req = 1'b1;
      bus.save_req    = 1'b1;
      tick();
      bus.restore_req = 1'b0;
      bus.save_req    = 1'b0;
      c = 1;
      while (bus.done !== 1'b1 && c < 2000) begin
         bus.save_req       = (c == 50);
         bus.bridge_wr      = (c == 50);
         bus.bridge_addr    = 32'h1000_00F0;
         bus.bridge_wr_data = 32'hA1B2_C3D4;
         tick();
         c++;
      end
      bus.save_req  = 1'b0;
      bus.bridge_wr = 1'b0;
      check("both_done_cycle", 32'(c), 32'd258);
      for (int i = 0; i < 10; i++) tick();
      check("both_one_done", 32'(done_cnt - d0), 32'd1);
      check("both_no_reads", 32'(rd_cnt), 32'd0);
      check("both_wr_cnt", 32'(wr_cnt), 32'd256);
      check("both_q_empty", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a restore, then a full restore again.
      wr_cnt = 0;
      d0 = done_cnt;
      push_restore();
      bus.restore_req = 1'b1;
      tick();
      bus.restore_req = 1'b0;
      c = 0;
      while (wr_cnt < 100 && c < 400) begin
         tick();
         c++;
      end
      check("mid_reached_100", 32'(wr_cnt), 32'd100);
      reset_n = 1'b0;
      tick();
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_req", 32'(bus.ram_req), 32'd0);
      reset_n = 1'b1;
      exp_q.delete();
      tick();
      check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
      bread("mid_buf_kept", 32'h1000_00F0, 32'hA1B2_C3D4);
      wr_cnt = 0;
      push_restore();
      run_dma(1'b1, 1'b0, "restore2");
      check("restore2_wr_cnt", 32'(wr_cnt), 32'd256);
      check("restore2_q_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
